// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl: multi-cycle Y86-64 SEQ sequencer owning the architectural PC.
// Steps one instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/PCUPDATE,
// handshakes with instruction/data memory, selects the next PC and tracks status.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           leave IDLE and begin execution at pc
//   icode, fetch_ack, imem_err,
//   ins_err                         fetch result and errors
//   valP, valC, valM, cnd           next-PC candidates and branch condition
//   dmem_ack, dmem_err              data memory completion and error
//   pc                              architectural PC
//   fetch_req, dec_en, exe_en,
//   mem_req, wb_en                  stage requests/enables
//   stat                            1=AOK 2=HLT 3=ADR 4=INS
//   busy                            high outside IDLE and STOP
// Optional: SEQ_CTRL_PERF_EN adds cyc_cnt (busy cycles) and ret_cnt (PCUPDATEs).
module seq_stage_ctrl #(
    parameter int                  DATA_WID = 64,
    parameter logic [DATA_WID-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [3:0]          icode,
    input  logic                fetch_ack,
    input  logic                imem_err,
    input  logic                ins_err,
    input  logic [DATA_WID-1:0] valP,
    input  logic [DATA_WID-1:0] valC,
    input  logic [DATA_WID-1:0] valM,
    input  logic                cnd,
    input  logic                dmem_ack,
    input  logic                dmem_err,
    output logic [DATA_WID-1:0] pc,
    output logic                fetch_req,
    output logic                dec_en,
    output logic                exe_en,
    output logic                mem_req,
    output logic                wb_en,
    output logic [2:0]          stat,
    output logic                busy
`ifdef SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]         cyc_cnt,
    output logic [31:0]         ret_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPDATE, STOP} state_t;
    localparam logic [3:0] I_HALT = 4'h0, I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_JXX = 4'h7,
                           I_CALL = 4'h8, I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
    localparam logic [2:0] S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;
    state_t              state, state_nx;
    logic [2:0]          stat_nx;
    logic [DATA_WID-1:0] pc_nx;
    logic                mem_op;
    assign mem_op = icode inside {I_RMMOV, I_MRMOV, I_PUSH, I_POP, I_CALL, I_RET};
    always_comb begin
        state_nx = state;
        stat_nx  = stat;
        pc_nx    = icode == I_CALL ? valC : icode == I_JXX ? (cnd ? valC : valP) : icode == I_RET ? valM : valP;
        case (state)
            IDLE:      state_nx = start ? FETCH : IDLE;
            FETCH: if (fetch_ack) begin
                // address fault outranks an illegal instruction
                state_nx = (imem_err || ins_err || icode == I_HALT) ? STOP : DECODE;
                stat_nx  = imem_err ? S_ADR : ins_err ? S_INS : icode == I_HALT ? S_HLT : stat;
            end
            DECODE:    state_nx = EXECUTE;
            EXECUTE:   state_nx = mem_op ? MEMORY : WRITEBACK;
            MEMORY: if (dmem_ack) begin
                state_nx = dmem_err ? STOP : WRITEBACK;
                stat_nx  = dmem_err ? S_ADR : stat;
            end
            WRITEBACK: state_nx = PCUPDATE;
            PCUPDATE:  state_nx = FETCH;
            default:   state_nx = STOP;
        endcase
    end
    // outputs are decoded from the next state so they appear registered with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            stat      <= S_AOK;
            fetch_req <= 1'b0;
            dec_en    <= 1'b0;
            exe_en    <= 1'b0;
            mem_req   <= 1'b0;
            wb_en     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            stat      <= stat_nx;
            if (state == PCUPDATE) pc <= pc_nx;
            fetch_req <= state_nx == FETCH;
            dec_en    <= state_nx == DECODE;
            exe_en    <= state_nx == EXECUTE;
            mem_req   <= state_nx == MEMORY;
            wb_en     <= state_nx == WRITEBACK;
            busy      <= !(state_nx inside {IDLE, STOP});
        end
    end
`ifdef SEQ_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'(busy);
            ret_cnt <= ret_cnt + 32'(state == PCUPDATE);
        end
    end
`endif
endmodule

// File: tb/tb_seq_stage_ctrl.sv
// tb_seq_stage_ctrl: scoreboard bench for seq_stage_ctrl; per-cycle expected
// stage outputs, pc and stat are queued as stimulus is driven and compared
// against captured DUT snapshots by each scenario task.
module tb_seq_stage_ctrl;
    typedef struct packed {
        logic [5:0]  ctl;
        logic [63:0] pc;
        logic [2:0]  stat;
    } snap_t;
    logic        clk, rst_n, start, fetch_ack, imem_err, ins_err, cnd, dmem_ack, dmem_err;
    logic [3:0]  icode;
    logic [63:0] valP, valC, valM, pc;
    logic        fetch_req, dec_en, exe_en, mem_req, wb_en, busy;
    logic [2:0]  stat;
`ifdef SEQ_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif
    snap_t       exp_q[$], obs_q[$];
    logic [63:0] exp_pc;
    logic [2:0]  exp_stat;
    int          exp_ret;
    int          n_cmp, n_bad;
    seq_stage_ctrl #(.DATA_WID(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .fetch_ack(fetch_ack),
        .imem_err(imem_err), .ins_err(ins_err), .valP(valP), .valC(valC), .valM(valM),
        .cnd(cnd), .dmem_ack(dmem_ack), .dmem_err(dmem_err), .pc(pc), .fetch_req(fetch_req),
        .dec_en(dec_en), .exe_en(exe_en), .mem_req(mem_req), .wb_en(wb_en), .stat(stat),
        .busy(busy)
`ifdef SEQ_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end
    function automatic snap_t mk(input logic [5:0] c);
        return '{ctl: c, pc: exp_pc, stat: exp_stat};
    endfunction
    function automatic snap_t now();
        return {fetch_req, dec_en, exe_en, mem_req, wb_en, busy, pc, stat};
    endfunction
    // queue expectation for the state after the next rising edge, then capture the DUT
    task automatic cyc(input snap_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs_q.push_back(now());
    endtask
    task automatic apply_reset;
        rst_n = 1'b0;
        {start, fetch_ack, imem_err, ins_err, cnd, dmem_ack, dmem_err} = '0;
        icode = 4'h1;
        {valP, valC, valM} = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_pc = 64'h0;
        exp_stat = 3'd1;
        exp_ret = 0;
    endtask
    task automatic do_start;
        start = 1'b1;
        cyc(mk(6'b100001));
        start = 1'b0;
    endtask
    // drive one instruction from FETCH and queue the cycle-by-cycle expectations
    task automatic instr(input logic [3:0] ic, input logic [63:0] vp, vc, vm, input logic c,
                         input int fw, dw, input logic ie, ne, de);
        logic mem_op;
        mem_op = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
        icode = ic; valP = vp; valC = vc; valM = vm; cnd = c;
        imem_err = ie; ins_err = ne;
        fetch_ack = 1'b0;
        repeat (fw) cyc(mk(6'b100001));
        fetch_ack = 1'b1;
        if (ie || ne || ic == 4'h0) begin
            exp_stat = ie ? 3'd3 : ne ? 3'd4 : 3'd2;
            cyc(mk(6'b000000));
            {fetch_ack, imem_err, ins_err} = '0;
            return;
        end
        cyc(mk(6'b010001));
        // stray acks, errors and start in DECODE/EXECUTE must change nothing
        {fetch_ack, dmem_ack, dmem_err, start, imem_err, ins_err} = '1;
        cyc(mk(6'b001001));
        cyc(mk(mem_op ? 6'b000101 : 6'b000011));
        {fetch_ack, dmem_ack, dmem_err, start, imem_err, ins_err} = '0;
        if (mem_op) begin
            repeat (dw) cyc(mk(6'b000101));
            dmem_ack = 1'b1;
            dmem_err = de;
            if (de) begin
                exp_stat = 3'd3;
                cyc(mk(6'b000000));
                {dmem_ack, dmem_err} = '0;
                return;
            end
            cyc(mk(6'b000011));
            dmem_ack = 1'b0;
        end
        cyc(mk(6'b000001));
        exp_pc = ic == 4'h8 ? vc : ic == 4'h7 ? (c ? vc : vp) : ic == 4'h9 ? vm : vp;
        exp_ret++;
        cyc(mk(6'b100001));
    endtask
    task automatic test_reset;
        apply_reset;
        rst_n = 1'b0;
        #2;
        exp_q.push_back(mk(6'b000000));
        obs_q.push_back(now());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) cyc(mk(6'b000000));
        while (exp_q.size() > 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset: got ctl=%b pc=%h stat=%0d, want ctl=%b pc=%h stat=%0d", o.ctl, o.pc, o.stat, e.ctl, e.pc, e.stat);
            end
        end
    endtask
    task automatic test_async_reset;
        apply_reset;
        do_start;
        instr(4'h7, 64'h5, 64'h100, 64'h0, 1'b1, 0, 0, 0, 0, 0);
        icode = 4'h5;
        fetch_ack = 1'b1;
        cyc(mk(6'b010001));
        fetch_ack = 1'b0;
        cyc(mk(6'b001001));
        cyc(mk(6'b000101));
        #2;
        rst_n = 1'b0;
        #1;
        exp_pc = 64'h0;
        exp_stat = 3'd1;
        exp_q.push_back(mk(6'b000000));
        obs_q.push_back(now());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(mk(6'b000000));
        while (exp_q.size() > 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL async_reset: got ctl=%b pc=%h stat=%0d, want ctl=%b pc=%h stat=%0d", o.ctl, o.pc, o.stat, e.ctl, e.pc, e.stat);
            end
        end
    endtask
    task automatic test_op_jxx_ret;
        apply_reset;
        do_start;
        instr(4'h7, 64'h9, 64'h100, 64'h0, 1'b1, 0, 0, 0, 0, 0);
        instr(4'h6, 64'h102, 64'h0, 64'h0, 1'b0, 0, 0, 0, 0, 0);
        instr(4'h7, 64'h10b, 64'h200, 64'h0, 1'b1, 1, 0, 0, 0, 0);
        instr(4'h7, 64'h209, 64'h40, 64'h0, 1'b1, 0, 0, 0, 0, 0);
        instr(4'h7, 64'h49, 64'h200, 64'h0, 1'b1, 0, 0, 0, 0, 0);
        instr(4'h7, 64'h209, 64'h40, 64'h0, 1'b0, 0, 0, 0, 0, 0);
        instr(4'h9, 64'h20a, 64'h0, 64'h1234, 1'b0, 0, 3, 0, 0, 0);
        instr(4'h8, 64'h123d, 64'h800, 64'h0, 1'b0, 2, 1, 0, 0, 0);
        instr(4'h3, 64'hffff_ffff_ffff_ffff, 64'h0, 64'h0, 1'b0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL op_jxx_ret: got ctl=%b pc=%h stat=%0d, want ctl=%b pc=%h stat=%0d", o.ctl, o.pc, o.stat, e.ctl, e.pc, e.stat);
            end
        end
    endtask
    task automatic test_back_to_back;
        logic [3:0] ops [11];
        ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
        apply_reset;
        do_start;
        for (int i = 0; i < 24; i++)
            instr(ops[$urandom_range(0, 10)], {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, 0);
        while (exp_q.size() > 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL back_to_back: got ctl=%b pc=%h stat=%0d, want ctl=%b pc=%h stat=%0d", o.ctl, o.pc, o.stat, e.ctl, e.pc, e.stat);
            end
        end
    endtask
    task automatic test_dmem_err;
        apply_reset;
        do_start;
        instr(4'h7, 64'h9, 64'h300, 64'h0, 1'b1, 0, 0, 0, 0, 0);
        instr(4'h4, 64'h30a, 64'h0, 64'h0, 1'b0, 0, 1, 0, 0, 1);
        start = 1'b1;
        fetch_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (3) cyc(mk(6'b000000));
        {start, fetch_ack, dmem_ack} = '0;
        while (exp_q.size() > 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL dmem_err: got ctl=%b pc=%h stat=%0d, want ctl=%b pc=%h stat=%0d", o.ctl, o.pc, o.stat, e.ctl, e.pc, e.stat);
            end
        end
    endtask
    task automatic test_fetch_err;
        apply_reset;
        do_start;
        instr(4'h1, 64'h0, 64'h0, 64'h0, 1'b0, 1, 0, 1, 1, 0);
        start = 1'b1;
        cyc(mk(6'b000000));
        apply_reset;
        do_start;
        instr(4'hc, 64'h0, 64'h0, 64'h0, 1'b0, 0, 0, 0, 1, 0);
        cyc(mk(6'b000000));
        while (exp_q.size() > 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL fetch_err: got ctl=%b pc=%h stat=%0d, want ctl=%b pc=%h stat=%0d", o.ctl, o.pc, o.stat, e.ctl, e.pc, e.stat);
            end
        end
    endtask
    task automatic test_halt;
        apply_reset;
        do_start;
        instr(4'h6, 64'h2, 64'h0, 64'h0, 1'b0, 0, 0, 0, 0, 0);
        instr(4'h7, 64'hb, 64'h30, 64'h0, 1'b1, 0, 0, 0, 0, 0);
        instr(4'h0, 64'h31, 64'h0, 64'h0, 1'b0, 2, 0, 0, 0, 0);
        start = 1'b1;
        repeat (2) cyc(mk(6'b000000));
        start = 1'b0;
        while (exp_q.size() > 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL halt: got ctl=%b pc=%h stat=%0d, want ctl=%b pc=%h stat=%0d", o.ctl, o.pc, o.stat, e.ctl, e.pc, e.stat);
            end
        end
`ifdef SEQ_CTRL_PERF_EN
        n_cmp++;
        if (ret_cnt !== 32'(exp_ret)) begin
            n_bad++;
            $display("FAIL halt_ret_cnt: got %0d, want %0d", ret_cnt, exp_ret);
        end
`endif
    endtask
    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        test_reset;
        test_async_reset;
        test_op_jxx_ret;
        test_back_to_back;
        test_dmem_err;
        test_fetch_err;
        test_halt;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
